// File: rtl/chess_cursor_ctrl_pkg.sv
// Shared button indices, selection FSM states and board defaults for the
// chess UI cursor controller.
package chess_ui_pkg;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_CENTER = 4;
    localparam int unsigned BTN_NUM    = 5;

    localparam int unsigned BOARD_COLS = 9;
    localparam int unsigned BOARD_ROWS = 10;

    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_PICKED = 2'd1,
        SEL_REQ    = 2'd2
    } sel_state_t;

endpackage

// File: rtl/chess_cursor_ctrl_cursor_axis.sv
// One cursor coordinate: registered position stepping by one square with
// either saturation or wrap-around at the board edges.
module cursor_axis #(
    parameter int unsigned MAX  = 8,
    parameter int unsigned W    = 4,
    parameter int unsigned WRAP = 0,
    parameter int unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         hold,
    output logic [W-1:0] pos
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);
    localparam logic [W-1:0] ONE_V  = W'(1);

    logic [W-1:0] pos_q, pos_d;

    // Edge compares use >= so an out-of-range value can never step past MAX.
    always_comb begin
        pos_d = pos_q;
        if (!hold) begin
            if (dec) begin
                if (pos_q == '0) begin
                    pos_d = (WRAP != 0) ? MAX_V : '0;
                end else begin
                    pos_d = pos_q - ONE_V;
                end
            end else if (inc) begin
                if (pos_q >= MAX_V) begin
                    pos_d = (WRAP != 0) ? '0 : MAX_V;
                end else begin
                    pos_d = pos_q + ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= INIT_V;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/chess_cursor_ctrl.sv
// Board cursor and pick/place selection FSM; issues move requests to the
// game logic over a valid/ready handshake.
module chess_cursor_ctrl
    import chess_ui_pkg::*;
#(
    parameter int unsigned COLS    = BOARD_COLS,
    parameter int unsigned ROWS    = BOARD_ROWS,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned WRAP    = 0,
    parameter int unsigned X_INIT  = 4,
    parameter int unsigned Y_INIT  = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BTN_NUM-1:0] s_sig,
    input  logic [BTN_NUM-1:0] l_sig,
    input  logic               piece_here,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               picked,
    output logic [COORD_W-1:0] src_x,
    output logic [COORD_W-1:0] src_y,
    output logic               mv_valid,
    output logic [COORD_W-1:0] mv_dst_x,
    output logic [COORD_W-1:0] mv_dst_y,
    input  logic               mv_ready,
    output logic               cancel
);

    sel_state_t         state_q, state_d;
    logic [COORD_W-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic               cancel_q, cancel_d;

    logic [BTN_NUM-1:0] step;
    logic               up_ev, down_ev, left_ev, right_ev, freeze;
    logic               select_ev, cancel_ev, at_src;

    // Single direction per cycle: UP > DOWN > LEFT > RIGHT.
    assign step     = s_sig | l_sig;
    assign up_ev    = step[BTN_UP];
    assign down_ev  = step[BTN_DOWN] & ~step[BTN_UP];
    assign left_ev  = step[BTN_LEFT] & ~step[BTN_UP] & ~step[BTN_DOWN];
    assign right_ev = step[BTN_RIGHT] & ~step[BTN_UP] & ~step[BTN_DOWN] & ~step[BTN_LEFT];
    assign freeze   = (state_q == SEL_REQ);

    cursor_axis #(
        .MAX  (COLS - 1),
        .W    (COORD_W),
        .WRAP (WRAP),
        .INIT (X_INIT)
    ) u_axis_x (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (right_ev),
        .dec   (left_ev),
        .hold  (freeze),
        .pos   (cur_x)
    );

    cursor_axis #(
        .MAX  (ROWS - 1),
        .W    (COORD_W),
        .WRAP (WRAP),
        .INIT (Y_INIT)
    ) u_axis_y (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (down_ev),
        .dec   (up_ev),
        .hold  (freeze),
        .pos   (cur_y)
    );

    assign select_ev = s_sig[BTN_CENTER];
    assign cancel_ev = l_sig[BTN_CENTER];
    assign at_src    = (cur_x == src_x_q) && (cur_y == src_y_q);

    // Selection uses the registered (pre-move) cursor of this cycle.
    always_comb begin
        state_d  = state_q;
        src_x_d  = src_x_q;
        src_y_d  = src_y_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        cancel_d = 1'b0;
        case (state_q)
            SEL_IDLE: begin
                if (select_ev && piece_here) begin
                    src_x_d = cur_x;
                    src_y_d = cur_y;
                    state_d = SEL_PICKED;
                end
            end
            SEL_PICKED: begin
                if (select_ev) begin
                    if (at_src) begin
                        state_d  = SEL_IDLE;
                        cancel_d = 1'b1;
                    end else begin
                        dst_x_d = cur_x;
                        dst_y_d = cur_y;
                        state_d = SEL_REQ;
                    end
                end else if (cancel_ev) begin
                    state_d  = SEL_IDLE;
                    cancel_d = 1'b1;
                end
            end
            SEL_REQ: begin
                if (mv_ready) begin
                    state_d = SEL_IDLE;
                end
            end
            default: begin
                state_d = SEL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEL_IDLE;
            src_x_q  <= '0;
            src_y_q  <= '0;
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_x_q  <= src_x_d;
            src_y_q  <= src_y_d;
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            cancel_q <= cancel_d;
        end
    end

    assign picked   = (state_q != SEL_IDLE);
    assign mv_valid = (state_q == SEL_REQ);
    assign src_x    = src_x_q;
    assign src_y    = src_y_q;
    assign mv_dst_x = dst_x_q;
    assign mv_dst_y = dst_y_q;
    assign cancel   = cancel_q;

endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Bench for chess_cursor_ctrl: a saturating and a wrapping instance share
// stimulus; a table, directed sequences and random traffic are checked.
module tb_chess_cursor_ctrl;

    localparam int COLS = 9;
    localparam int ROWS = 10;
    localparam int XI   = 4;
    localparam int YI   = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] s_sig = '0;
    logic [4:0] l_sig = '0;
    logic       piece_here = 1'b0;
    logic       mv_ready = 1'b0;

    logic [3:0] o_x [2];
    logic [3:0] o_y [2];
    logic [3:0] o_sx [2];
    logic [3:0] o_sy [2];
    logic [3:0] o_dx [2];
    logic [3:0] o_dy [2];
    logic       o_pk [2];
    logic       o_mv [2];
    logic       o_cn [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chess_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .COORD_W(4), .WRAP(0), .X_INIT(XI), .Y_INIT(YI)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .s_sig(s_sig), .l_sig(l_sig), .piece_here(piece_here),
        .cur_x(o_x[0]), .cur_y(o_y[0]), .picked(o_pk[0]), .src_x(o_sx[0]), .src_y(o_sy[0]),
        .mv_valid(o_mv[0]), .mv_dst_x(o_dx[0]), .mv_dst_y(o_dy[0]), .mv_ready(mv_ready),
        .cancel(o_cn[0])
    );

    chess_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .COORD_W(4), .WRAP(1), .X_INIT(XI), .Y_INIT(YI)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .s_sig(s_sig), .l_sig(l_sig), .piece_here(piece_here),
        .cur_x(o_x[1]), .cur_y(o_y[1]), .picked(o_pk[1]), .src_x(o_sx[1]), .src_y(o_sy[1]),
        .mv_valid(o_mv[1]), .mv_dst_x(o_dx[1]), .mv_dst_y(o_dy[1]), .mv_ready(mv_ready),
        .cancel(o_cn[1])
    );

    // Reference model: mode 0 idle, 1 holding a source square, 2 awaiting acceptance.
    int mx [2], my [2], mmode [2], msx [2], msy [2], mdx [2], mdy [2], mcn [2];

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, inst, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = XI; my[i] = YI; mmode[i] = 0;
            msx[i] = 0; msy[i] = 0; mdx[i] = 0; mdy[i] = 0; mcn[i] = 0;
        end
    endtask

    task automatic model_step(input logic [4:0] s, input logic [4:0] l, input logic ph, input logic rdy);
        logic [4:0] st;
        int nx, ny;
        st = s | l;
        for (int i = 0; i < 2; i++) begin
            nx = mx[i]; ny = my[i];
            if (mmode[i] != 2) begin
                if (st[0])      ny = (i == 1) ? (my[i] + ROWS - 1) % ROWS : ((my[i] > 0) ? my[i] - 1 : 0);
                else if (st[1]) ny = (i == 1) ? (my[i] + 1) % ROWS : ((my[i] < ROWS - 1) ? my[i] + 1 : ROWS - 1);
                else if (st[2]) nx = (i == 1) ? (mx[i] + COLS - 1) % COLS : ((mx[i] > 0) ? mx[i] - 1 : 0);
                else if (st[3]) nx = (i == 1) ? (mx[i] + 1) % COLS : ((mx[i] < COLS - 1) ? mx[i] + 1 : COLS - 1);
            end
            mcn[i] = 0;
            if (mmode[i] == 0) begin
                if (s[4] && ph) begin
                    msx[i] = mx[i]; msy[i] = my[i]; mmode[i] = 1;
                end
            end else if (mmode[i] == 1) begin
                if (s[4]) begin
                    if (mx[i] == msx[i] && my[i] == msy[i]) begin
                        mmode[i] = 0; mcn[i] = 1;
                    end else begin
                        mdx[i] = mx[i]; mdy[i] = my[i]; mmode[i] = 2;
                    end
                end else if (l[4]) begin
                    mmode[i] = 0; mcn[i] = 1;
                end
            end else if (rdy) begin
                mmode[i] = 0;
            end
            mx[i] = nx; my[i] = ny;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk("cur_x", i, int'(o_x[i]), mx[i]);
            chk("cur_y", i, int'(o_y[i]), my[i]);
            chk("picked", i, int'(o_pk[i]), (mmode[i] != 0) ? 1 : 0);
            chk("mv_valid", i, int'(o_mv[i]), (mmode[i] == 2) ? 1 : 0);
            chk("src_x", i, int'(o_sx[i]), msx[i]);
            chk("src_y", i, int'(o_sy[i]), msy[i]);
            chk("dst_x", i, int'(o_dx[i]), mdx[i]);
            chk("dst_y", i, int'(o_dy[i]), mdy[i]);
            chk("cancel", i, int'(o_cn[i]), mcn[i]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic tick(input logic [4:0] s, input logic [4:0] l, input logic ph, input logic rdy);
        s_sig = s; l_sig = l; piece_here = ph; mv_ready = rdy;
        @(posedge clk);
        model_step(s, l, ph, rdy);
        @(negedge clk);
        s_sig = '0; l_sig = '0; piece_here = 1'b0; mv_ready = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_sig = '0; l_sig = '0; piece_here = 1'b0; mv_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_model();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] s;
        logic [4:0] l;
        logic       ph;
        logic       rdy;
        int         ex, ey, epk, emv, ecn;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [4:0] s, input logic [4:0] l, input logic ph, input logic rdy,
                       input int ex, input int ey, input int epk, input int emv, input int ecn);
        vec_t v;
        v.s = s; v.l = l; v.ph = ph; v.rdy = rdy;
        v.ex = ex; v.ey = ey; v.epk = epk; v.emv = emv; v.ecn = ecn;
        tbl.push_back(v);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lx [6];
        // Saturating instance from reset: U=1 D=2 L=4 R=8 C=16
        add(8, 0, 0, 0, 5, 9, 0, 0, 0);
        add(8, 0, 0, 0, 6, 9, 0, 0, 0);
        add(8, 0, 0, 0, 7, 9, 0, 0, 0);
        add(2, 0, 0, 0, 7, 9, 0, 0, 0);
        add(5, 0, 0, 0, 7, 8, 0, 0, 0);
        add(4, 0, 0, 0, 6, 8, 0, 0, 0);
        add(4, 0, 0, 0, 5, 8, 0, 0, 0);
        add(4, 0, 0, 0, 4, 8, 0, 0, 0);
        add(2, 0, 0, 0, 4, 9, 0, 0, 0);
        add(16, 0, 0, 0, 4, 9, 0, 0, 0);
        add(16, 0, 1, 0, 4, 9, 1, 0, 0);
        add(1, 0, 0, 0, 4, 8, 1, 0, 0);
        add(1, 0, 0, 0, 4, 7, 1, 0, 0);
        add(16, 0, 0, 0, 4, 7, 1, 1, 0);
        for (int k = 0; k < 5; k++) add(2, 0, 0, 0, 4, 7, 1, 1, 0);
        add(0, 0, 0, 1, 4, 7, 0, 0, 0);
        add(16, 0, 1, 0, 4, 7, 1, 0, 0);
        add(16, 0, 1, 0, 4, 7, 0, 0, 1);
        add(0, 0, 0, 0, 4, 7, 0, 0, 0);
        add(16, 0, 1, 0, 4, 7, 1, 0, 0);
        add(0, 16, 0, 0, 4, 7, 0, 0, 1);
        add(0, 16, 0, 0, 4, 7, 0, 0, 0);
        add(16, 0, 1, 0, 4, 7, 1, 0, 0);
        add(1, 0, 0, 0, 4, 6, 1, 0, 0);
        add(17, 16, 0, 0, 4, 5, 1, 1, 0);
        add(2, 16, 0, 0, 4, 5, 1, 1, 0);
        add(0, 0, 0, 1, 4, 5, 0, 0, 0);

        @(negedge clk);
        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].s, tbl[i].l, tbl[i].ph, tbl[i].rdy);
            chk("tbl_x", i, int'(o_x[0]), tbl[i].ex);
            chk("tbl_y", i, int'(o_y[0]), tbl[i].ey);
            chk("tbl_picked", i, int'(o_pk[0]), tbl[i].epk);
            chk("tbl_mv_valid", i, int'(o_mv[0]), tbl[i].emv);
            chk("tbl_cancel", i, int'(o_cn[0]), tbl[i].ecn);
        end

        // Long-press LEFT repeats saturate at column 0
        lx = '{3, 2, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(0, 4, 0, 0);
            chk("long_left_x", k, int'(o_x[0]), lx[k]);
            for (int j = 0; j < 31; j++) tick(0, 0, 0, 0);
        end

        // Edge behaviour at the bottom row for both instances
        do_reset();
        tick(2, 0, 0, 0);
        chk("down_sat_y", 0, int'(o_y[0]), 9);
        chk("down_wrap_y", 1, int'(o_y[1]), 0);
        tick(1, 0, 0, 0);
        chk("up_wrap_y", 1, int'(o_y[1]), 9);

        // Asynchronous reset while a request is pending
        do_reset();
        tick(16, 0, 1, 0);
        tick(1, 0, 0, 0);
        tick(16, 0, 0, 0);
        chk("req_mv_valid", 0, int'(o_mv[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mv_valid", i, int'(o_mv[i]), 0);
            chk("rst_picked", i, int'(o_pk[i]), 0);
            chk("rst_x", i, int'(o_x[i]), XI);
            chk("rst_y", i, int'(o_y[i]), YI);
        end
        @(negedge clk);
        do_reset();

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [4:0] rs, rl;
            rs = 5'($urandom & $urandom);
            rl = 5'($urandom & $urandom & $urandom);
            tick(rs, rl, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
